spi_readback_tx: RTL and testbench

- Transmit side of the ARM↔FPGA SPI link. The existing SPI receiver only accepts configuration writes; this block adds register readback on miso.
- The ARM sends a 16-bit frame, MSB first. Bits 15:12 carry the command and bits 11:8 carry a register address.
- For a read command, the block fetches one 8-bit value through a simple read port and shifts it out on miso during bits 7:0 of the same frame.
- SPI pins are oversampled in the pck0 domain. No logic runs on spck.

---
 rtl/spi_readback_tx_if.sv | 13 +
 rtl/spi_readback_tx.sv | 165 ++++++++++++++++
 tb/tb_spi_readback_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_readback_tx_if.sv
// Register read port between the SPI readback transmitter and the register file.
// The master issues a one-cycle rd_strobe with rd_addr; rd_data is sampled one cycle later.
interface spi_readback_tx_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              rd_strobe;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_strobe, output rd_addr, input rd_data);
  modport slave  (input rd_strobe, input rd_addr, output rd_data);
endinterface

// File: rtl/spi_readback_tx.sv
// SPI mode-0 readback transmitter: decodes a 16-bit frame, fetches one register, shifts it out on miso.
// SPI pins are oversampled in pck0; every pin edge acts SYNC_STAGES+1 pck0 cycles after it occurs.
module spi_readback_tx #(
  parameter logic [3:0] READ_CMD    = 4'b0011,
  parameter int         SYNC_STAGES = 2,
  parameter int         ADDR_W      = 4,
  parameter int         DATA_W      = 8
) (
  input  logic pck0,
  input  logic rst,
  input  logic spck,
  input  logic ncs,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic frame_err,
  spi_readback_tx_if.master rd_bus
);
  localparam int         CMD_W   = 4 + ADDR_W;
  localparam logic [4:0] CNT_CMD = 5'(CMD_W);
  localparam logic [4:0] CNT_END = 5'(CMD_W + DATA_W);
  localparam logic [4:0] CNT_MAX = 5'd31;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [SYNC_STAGES-1:0] spck_sync_q, ncs_sync_q, mosi_sync_q;
  logic                   spck_prev_q, ncs_prev_q;
  logic                   spck_s, ncs_s, mosi_s;
  logic                   spck_rise, spck_fall, ncs_rise, ncs_fall;

  logic [2:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d, cmd_next;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              frame_err_q, frame_err_d;
  logic              rd_strobe_q, rd_strobe_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  assign spck_s    = spck_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign spck_rise = spck_s & ~spck_prev_q;
  assign spck_fall = ~spck_s & spck_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign cmd_next  = {cmd_q[CMD_W-2:0], mosi_s};

  always_ff @(posedge pck0) begin
    if (rst) begin
      spck_sync_q <= '0;
      ncs_sync_q  <= '1;
      mosi_sync_q <= '0;
      spck_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      spck_sync_q <= {spck_sync_q[SYNC_STAGES-2:0], spck};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      spck_prev_q <= spck_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    frame_err_d = 1'b0;
    rd_strobe_d = 1'b0;
    rd_addr_d   = rd_addr_q;

    if (spck_rise && !ncs_s && state_q != S_IDLE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 5'd1;
    end

    // End of frame takes priority over any spck edge seen in the same cycle.
    if (ncs_rise) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      miso_d      = 1'b0;
      miso_oe_d   = 1'b0;
      frame_err_d = (cnt_q != 5'd0) && (cnt_q != CNT_END);
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          cmd_d = '0;
          tx_d  = '0;
          if (ncs_fall) state_d = S_CMD;
        end
        S_CMD: begin
          if (spck_rise) begin
            cmd_d = cmd_next;
            if (cnt_q == CNT_CMD - 5'd1) begin
              if (cmd_next[CMD_W-1 -: 4] == READ_CMD) begin
                state_d     = S_FETCH;
                rd_strobe_d = 1'b1;
                rd_addr_d   = cmd_next[ADDR_W-1:0];
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          tx_d      = rd_bus.rd_data;
          miso_d    = rd_bus.rd_data[DATA_W-1];
          miso_oe_d = 1'b1;
          state_d   = S_DATA;
        end
        S_DATA: begin
          // The falling edge right after the last command bit precedes the MSB sample; skip it.
          if (spck_fall && cnt_q > CNT_CMD) begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            miso_d = tx_q[DATA_W-2];
          end
          if (spck_rise && cnt_q == CNT_END - 5'd1) state_d = S_DONE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pck0) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      frame_err_q <= frame_err_d;
      rd_strobe_q <= rd_strobe_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign miso             = miso_q;
  assign miso_oe          = miso_oe_q;
  assign frame_err        = frame_err_q;
  assign rd_bus.rd_strobe = rd_strobe_q;
  assign rd_bus.rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_spi_readback_tx.sv
// Directed and random frame bench for spi_readback_tx; an ARM-side model drives SPI and samples miso.
module tb_spi_readback_tx;
  localparam int HALF = 40;

  logic pck0 = 1'b0;
  logic rst  = 1'b1;
  logic spck = 1'b0;
  logic ncs  = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, frame_err;

  logic [7:0] mem [16];
  int   checks = 0;
  int   failures = 0;
  int   strobe_cnt = 0;
  int   ferr_cnt = 0;
  logic [3:0] exp_addr = 4'h0;
  bit   exp_quiet = 1'b0;
  bit   mon_en = 1'b0;
  int   phase = 3;

  always #5 pck0 = ~pck0;

  spi_readback_tx_if #(.ADDR_W(4), .DATA_W(8)) rd_if ();

  spi_readback_tx #(
    .READ_CMD(4'b0011), .SYNC_STAGES(2), .ADDR_W(4), .DATA_W(8)
  ) dut (
    .pck0(pck0), .rst(rst), .spck(spck), .ncs(ncs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .frame_err(frame_err),
    .rd_bus(rd_if.master)
  );

  // Register file: registered read, data valid the cycle after the strobe
  always @(posedge pck0) begin
    if (rst) rd_if.rd_data <= 8'h00;
    else if (rd_if.rd_strobe) rd_if.rd_data <= mem[rd_if.rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge pck0) begin
    if (mon_en && !rst) begin
      if (rd_if.rd_strobe === 1'b1) begin
        strobe_cnt++;
        check("rd_addr_at_strobe", {28'd0, rd_if.rd_addr}, {28'd0, exp_addr});
      end
      if (frame_err === 1'b1) ferr_cnt++;
      if (exp_quiet) begin
        check("quiet_miso", {31'd0, miso}, 32'd0);
        check("quiet_miso_oe", {31'd0, miso_oe}, 32'd0);
      end
    end
  end

  function automatic bit model_is_read(input logic [15:0] frame);
    return frame[15:12] == 4'h3;
  endfunction

  function automatic logic [7:0] model_data(input logic [15:0] frame);
    return mem[frame[11:8]];
  endfunction

  task automatic spi_xfer(input logic [31:0] word, input int nbits, input bit keep_ncs,
                          output logic [31:0] rx);
    rx = '0;
    @(posedge pck0);
    #(phase);
    ncs  = 1'b0;
    mosi = word[5'(nbits - 1)];
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      spck = 1'b1;
      rx   = {rx[30:0], miso};
      #(HALF);
      spck = 1'b0;
      if (i + 1 < nbits) mosi = word[5'(nbits - 2 - i)];
      #(HALF);
    end
    if (!keep_ncs) begin
      ncs = 1'b1;
      #(2 * HALF);
    end
  endtask

  task automatic begin_frame(input logic [3:0] addr, input bit quiet);
    strobe_cnt = 0;
    ferr_cnt   = 0;
    exp_addr   = addr;
    exp_quiet  = quiet;
    mon_en     = 1'b1;
  endtask

  task automatic end_frame(input string name, input int exp_str, input int exp_ferr);
    repeat (6) @(posedge pck0);
    check({name, "_strobes"}, strobe_cnt, exp_str);
    check({name, "_frame_err"}, ferr_cnt, exp_ferr);
    exp_quiet = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_miso"}, {31'd0, miso}, 32'd0);
    check({name, "_miso_oe"}, {31'd0, miso_oe}, 32'd0);
    check({name, "_rd_strobe"}, {31'd0, rd_if.rd_strobe}, 32'd0);
    check({name, "_rd_addr"}, {28'd0, rd_if.rd_addr}, 32'd0);
    check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog time limit reached actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    logic [15:0] frame;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);

    repeat (3) @(posedge pck0);
    #1;
    check_all_zero("reset");
    #1 rst = 1'b0;

    // Readback of address 5
    mem[5] = 8'hA6;
    begin_frame(4'h5, 1'b0);
    spi_xfer(32'h3500, 16, 1'b0, rx);
    end_frame("read35", 1, 0);
    check("read35_miso_bits", {24'd0, rx[7:0]}, 32'b10100110);
    check("read35_rd_addr_held", {28'd0, rd_if.rd_addr}, 32'h5);

    // Write frame: the block stays silent
    begin_frame(4'h0, 1'b1);
    spi_xfer(32'h1042, 16, 1'b0, rx);
    end_frame("write1042", 0, 0);

    // Abort after 11 bits of read 0x3C
    mem[12] = 8'h3F;
    begin_frame(4'hC, 1'b0);
    spi_xfer(32'h1E0, 11, 1'b1, rx);
    check("abort_oe_before", {31'd0, miso_oe}, 32'd1);
    check("abort_miso_bit4", {31'd0, miso}, 32'd1);
    check("abort_rx_bits", {29'd0, rx[2:0]}, 32'b001);
    ncs = 1'b1;
    repeat (3) @(posedge pck0);
    #1;
    check("abort_oe_after", {31'd0, miso_oe}, 32'd0);
    check("abort_miso_after", {31'd0, miso}, 32'd0);
    end_frame("abort3C", 1, 1);

    // 20-bit overrun frame, then a back-to-back read
    mem[10] = 8'hC3;
    begin_frame(4'hA, 1'b0);
    spi_xfer(32'h3A000, 20, 1'b0, rx);
    end_frame("overrun3A", 1, 1);
    check("overrun3A_data", {24'd0, rx[11:4]}, 32'hC3);
    mem[11] = 8'h91;
    begin_frame(4'hB, 1'b0);
    spi_xfer(32'h3B00, 16, 1'b0, rx);
    end_frame("b2b3B", 1, 0);
    check("b2b3B_data", {24'd0, rx[7:0]}, 32'h91);

    // Reset during the data phase of read 0x37
    mem[7] = 8'hE4;
    begin_frame(4'h7, 1'b0);
    spi_xfer(32'h370, 12, 1'b1, rx);
    @(posedge pck0);
    #2 rst = 1'b1;
    @(posedge pck0);
    #1;
    check_all_zero("midreset");
    #1 rst = 1'b0;
    ncs = 1'b1;
    end_frame("reset37", 1, 0);
    mem[2] = 8'h5C;
    begin_frame(4'h2, 1'b0);
    spi_xfer(32'h3200, 16, 1'b0, rx);
    end_frame("after_reset32", 1, 0);
    check("after_reset32_data", {24'd0, rx[7:0]}, 32'h5C);

    // Random frames at spck = pck0/8 with random phase
    for (int n = 0; n < 200; n++) begin
      phase = $urandom_range(1, 9);
      if ($urandom_range(0, 9) == 0)
        frame = {4'($urandom_range(1, 2)), 4'($urandom_range(0, 15)), 8'($urandom)};
      else
        frame = {4'h3, 4'($urandom_range(0, 15)), 8'($urandom)};
      mem[frame[11:8]] = 8'($urandom);
      begin_frame(frame[11:8], !model_is_read(frame));
      spi_xfer({16'd0, frame}, 16, 1'b0, rx);
      end_frame("random", model_is_read(frame) ? 1 : 0, 0);
      if (model_is_read(frame))
        check("random_data", {24'd0, rx[7:0]}, {24'd0, model_data(frame)});
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
